plic_lite: RTL and testbench
============================

Name: plic_lite

Overview:
- Wishbone slave platform-level interrupt controller; sits beside the CLINT on the system bus.
- Arbitrates NSRC level-triggered external interrupt sources (UART, GPIO, ...) by programmable priority.
- Presents the winner to the core as a machine external interrupt, gated by mstatus.MIE and mie.MEIE.
- Provides claim/complete handshake registers for the trap handler.

Parameters:
- NSRC, 8, number of interrupt sources; IDs 1..NSRC, ID 0 means "none"
- PRIO_W, 3, priority width; priority 0 means never interrupt
- ID_W, 4, width of source ID (>= clog2(NSRC+1))

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_sel_i  in  4  byte selects; ignored, all accesses are full-word
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- irq_src_i  in  NSRC  level interrupt inputs; bit k-1 = source ID k; synchronous to wb_clk_i
- csr_mie  in  32  mie CSR; bit 11 = MEIE
- csr_mstatus  in  32  mstatus CSR; bit 3 = MIE
- Interrupt  out  1  external interrupt request to core
- Exception_code  out  31  7'd11 when Interrupt is asserted, else 0

Behaviour:
- Reset (async, active-high) clears the following to 0: wb_ack_o, wb_dat_o, Interrupt, Exception_code, all priority, enable, pending and in_service bits, threshold, max_id and max_prio. A reset mid-access drops ack immediately; that access is lost.
- Register map, offsets from `PLIC_BASE`:
  - 0x000000+4*k: priority[k], k=1..NSRC, RW, bits [PRIO_W-1:0].
  - 0x001000: pending, RO, bit k = source k.
  - 0x002000: enable, RW, bit k.
  - 0x200000: threshold, RW, [PRIO_W-1:0].
  - 0x200004: claim on read, complete on write.
  - Unmapped reads return 0; unmapped writes are ignored.
- Bus handshake:
  - Access = wb_cyc_i & wb_stb_i & !wb_ack_o.
  - ack asserts the cycle after the access and lasts exactly 1 cycle, so back-to-back strobes get ack every other cycle.
  - Read data is valid with ack. Register writes take effect on the ack edge.
- Gateway, per source k:
  - pending[k] sets when irq_src_i[k-1]=1 and in_service[k]=0.
  - A claim that returns k clears pending[k] and sets in_service[k]; clear wins over a same-cycle set.
  - A complete write with data==k clears in_service[k] only if it is set. Otherwise the write is ignored, with no error.
  - While in_service[k]=1, new pending for k is blocked.
  - A level still high after complete re-pends on the next cycle.
- Arbiter:
  - Candidate set = pending & enable & (priority > threshold).
  - Winner is the highest priority; ties go to the lowest ID.
  - Result is registered into max_id/max_prio every cycle, with 1-cycle latency after any input or register change.
  - No candidate gives max_id=0.
- Claim read returns max_id as registered in the cycle of the access. If it is 0, no state changes.
- Interrupt/Exception_code are registered from (max_id!=0) & csr_mstatus[3] & csr_mie[11]. Total latency from irq_src_i rising to Interrupt is 3 cycles: pending, then max_id, then Interrupt.
- Claim and complete of the same ID in consecutive accesses are legal.
- A complete for a different ID than the last claim is legal (nested handling).

Decomposition:
- Shared defines file holds: `PLIC_BASE`, register offsets, `ZeroWord`, `RegBus`, and the machine external cause code (11).
- Natural sub-module: plic_arbiter. It is purely combinational, with a priority/ID tree from (pending, enable, priority[], threshold) to (id, prio). It is instantiated once; the registers stay in plic_lite.

Test Plan:
1. Reset, then read pending/enable/threshold/claim: all read 0; Interrupt=0; ack is one cycle per access.
2. prio[3]=2, enable=0x8, mstatus.MIE=1, mie.MEIE=1, raise irq 3 → Interrupt=1 and Exception_code=11 three cycles later; claim reads 3; pending bit 3 clears; Interrupt drops within 2 cycles.
3. prio[2]=5, prio[5]=5, prio[6]=7, all enabled, raise 2/5/6 together → claims return 6, then 2, then 5 (tie goes to lowest ID).
4. threshold=4, prio[1]=4, irq 1 high → Interrupt stays 0 and claim returns 0; set threshold=3 → Interrupt=1.
5. Claim 4 with irq 4 held high → pending stays blocked; complete with 7 is ignored; complete with 4 → pending re-sets next cycle and claim returns 4 again.
6. Assert wb_rst_i asynchronously mid-access while an interrupt is pending → wb_ack_o and Interrupt drop to 0 without a clock edge; all registers read 0 after release.

Source files
------------

// File: rtl/plic_lite_pkg.sv
// plic_lite shared definitions
// bus geometry, register map and cause code
package plic_lite_pkg;

  localparam int REG_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [31:0] PLIC_BASE = 32'h0C00_0000;

  // low address bits that select a register inside the block
  localparam int OFF_W = 22;

  localparam logic [OFF_W-1:0] OFF_PRIO  = 22'h00_0000;
  localparam logic [OFF_W-1:0] OFF_PEND  = 22'h00_1000;
  localparam logic [OFF_W-1:0] OFF_EN    = 22'h00_2000;
  localparam logic [OFF_W-1:0] OFF_THR   = 22'h20_0000;
  localparam logic [OFF_W-1:0] OFF_CLAIM = 22'h20_0004;

  // machine external interrupt cause
  localparam logic [30:0] CAUSE_MEXT = 31'd11;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PRIO,
    REG_PEND,
    REG_EN,
    REG_THR,
    REG_CLAIM
  } reg_sel_e;

  // word offset of a byte address; byte lanes are not decoded
  function automatic logic [OFF_W-1:0] word_off(
    input logic [31:0] adr
  );
    return {adr[OFF_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/plic_arbiter.sv
// plic_lite priority arbiter
// combinational tree: eligible sources -> winning id/prio
module plic_arbiter #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W   = 4
) (
  input  logic [NSRC:1]             pending,
  input  logic [NSRC:1]             enable,
  input  logic [NSRC:1][PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]         threshold,
  output logic [ID_W-1:0]           win_id,
  output logic [PRIO_W-1:0]         win_prio
);

  localparam int LEAVES = 1 << $clog2(NSRC);

  logic [NSRC:1] cand;

  // a source competes only when pending, enabled and above threshold
  always_comb begin
    cand = '0;
    for (int k = 1; k <= NSRC; k++) begin
      cand[k] = pending[k] & enable[k]
              & (prio[k] > threshold);
    end
  end

  // heap-ordered tree; node n has children 2n and 2n+1.
  // left child always covers lower ids, so it keeps ties.
  for (genvar n = 1; n < 2 * LEAVES; n++) begin : g_node
    logic [ID_W-1:0]   id;
    logic [PRIO_W-1:0] pr;

    if (n >= LEAVES) begin : g_leaf
      localparam int K = n - LEAVES + 1;
      if (K <= NSRC) begin : g_src
        assign id = cand[K] ? ID_W'(K) : '0;
        assign pr = cand[K] ? prio[K] : '0;
      end else begin : g_pad
        assign id = '0;
        assign pr = '0;
      end
    end else begin : g_inner
      logic take_r;
      assign take_r = g_node[2*n+1].pr > g_node[2*n].pr;
      assign id = take_r ? g_node[2*n+1].id
                         : g_node[2*n].id;
      assign pr = take_r ? g_node[2*n+1].pr
                         : g_node[2*n].pr;
    end
  end

  assign win_id   = g_node[1].id;
  assign win_prio = g_node[1].pr;

endmodule

// File: rtl/plic_lite.sv
// plic_lite: wishbone platform-level interrupt controller
// gateways, registers, claim/complete and core irq
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W   = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [REG_BUS-1:0] wb_dat_i,
  output logic [REG_BUS-1:0] wb_dat_o,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic               wb_ack_o,
  input  logic [NSRC-1:0]    irq_src_i,
  input  logic [31:0]        csr_mie,
  input  logic [31:0]        csr_mstatus,
  output logic               Interrupt,
  output logic [30:0]        Exception_code
);

  localparam logic [9:0] PIDX_MAX = 10'(NSRC);

  logic [NSRC:1][PRIO_W-1:0] prio;
  logic [NSRC:1]             enable;
  logic [NSRC:1]             pending;
  logic [NSRC:1]             in_service;
  logic [PRIO_W-1:0]         threshold;
  logic [ID_W-1:0]           max_id;
  logic [PRIO_W-1:0]         max_prio;

  logic [ID_W-1:0]   arb_id;
  logic [PRIO_W-1:0] arb_prio;

  logic              access;
  logic              wr;
  logic              rd;
  logic              base_hit;
  logic [OFF_W-1:0]  off;
  logic [9:0]        pidx;
  reg_sel_e          rsel;
  logic [REG_BUS-1:0] rd_data;
  logic [NSRC:1]     claim_vec;
  logic [NSRC:1]     cmpl_vec;
  logic              irq_next;

  // bits the block has no use for
  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0],
                       csr_mie[31:12], csr_mie[10:0],
                       csr_mstatus[31:4],
                       csr_mstatus[2:0], max_prio};

  // a new access is only taken while no ack is out
  assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = access & wb_we_i;
  assign rd     = access & ~wb_we_i;

  assign off      = word_off(wb_adr_i);
  assign pidx     = off[11:2];
  assign base_hit = wb_adr_i[31:OFF_W]
                 == PLIC_BASE[31:OFF_W];

  // register select from the word offset
  always_comb begin
    rsel = REG_NONE;
    if (base_hit) begin
      unique case (1'b1)
        (off[OFF_W-1:12] == OFF_PRIO[OFF_W-1:12])
          && (pidx >= 10'd1) && (pidx <= PIDX_MAX):
          rsel = REG_PRIO;
        off == OFF_PEND:  rsel = REG_PEND;
        off == OFF_EN:    rsel = REG_EN;
        off == OFF_THR:   rsel = REG_THR;
        off == OFF_CLAIM: rsel = REG_CLAIM;
        default:          rsel = REG_NONE;
      endcase
    end
  end

  // read mux; bit 0 of pending/enable is the unused id 0
  always_comb begin
    rd_data = ZERO_WORD;
    unique case (rsel)
      REG_PRIO: begin
        for (int k = 1; k <= NSRC; k++) begin
          if (pidx == 10'(k))
            rd_data[PRIO_W-1:0] = prio[k];
        end
      end
      REG_PEND:  rd_data[NSRC:1]     = pending;
      REG_EN:    rd_data[NSRC:1]     = enable;
      REG_THR:   rd_data[PRIO_W-1:0] = threshold;
      REG_CLAIM: rd_data[ID_W-1:0]   = max_id;
      default:   rd_data = ZERO_WORD;
    endcase
  end

  // one-hot claim and complete strobes per source id
  always_comb begin
    claim_vec = '0;
    cmpl_vec  = '0;
    for (int k = 1; k <= NSRC; k++) begin
      claim_vec[k] = rd && (rsel == REG_CLAIM)
                  && (max_id == ID_W'(k));
      cmpl_vec[k]  = wr && (rsel == REG_CLAIM)
                  && (wb_dat_i == 32'(k))
                  && in_service[k];
    end
  end

  // single-cycle ack with read data registered beside it
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= ZERO_WORD;
    end else begin
      wb_ack_o <= access;
      if (rd)
        wb_dat_o <= rd_data;
    end
  end

  // programmable priority, enable and threshold
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      prio      <= '0;
      enable    <= '0;
      threshold <= '0;
    end else if (wr) begin
      unique case (rsel)
        REG_PRIO: begin
          for (int k = 1; k <= NSRC; k++) begin
            if (pidx == 10'(k))
              prio[k] <= wb_dat_i[PRIO_W-1:0];
          end
        end
        REG_EN:  enable    <= wb_dat_i[NSRC:1];
        REG_THR: threshold <= wb_dat_i[PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // gateways: claim beats a same-cycle set, in-service blocks
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pending    <= '0;
      in_service <= '0;
    end else begin
      pending    <= (pending | (irq_src_i & ~in_service))
                  & ~claim_vec;
      in_service <= (in_service | claim_vec) & ~cmpl_vec;
    end
  end

  plic_arbiter #(
    .NSRC   (NSRC),
    .PRIO_W (PRIO_W),
    .ID_W   (ID_W)
  ) u_arb (
    .pending   (pending),
    .enable    (enable),
    .prio      (prio),
    .threshold (threshold),
    .win_id    (arb_id),
    .win_prio  (arb_prio)
  );

  // arbitration result, re-sampled every cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      max_id   <= '0;
      max_prio <= '0;
    end else begin
      max_id   <= arb_id;
      max_prio <= arb_prio;
    end
  end

  assign irq_next = (max_id != '0)
                  & csr_mstatus[3] & csr_mie[11];

  // core request gated by mstatus.MIE and mie.MEIE
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      Interrupt      <= 1'b0;
      Exception_code <= '0;
    end else begin
      Interrupt      <= irq_next;
      Exception_code <= irq_next ? CAUSE_MEXT : '0;
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// plic_lite bench: directed steps plus random rounds
// checked against a rule-level model of the controller
module tb_plic_lite;

  localparam logic [31:0] BASE  = 32'h0C00_0000;
  localparam logic [31:0] A_PND = BASE + 32'h0000_1000;
  localparam logic [31:0] A_EN  = BASE + 32'h0000_2000;
  localparam logic [31:0] A_THR = BASE + 32'h0020_0000;
  localparam logic [31:0] A_CLM = BASE + 32'h0020_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic [3:0]  sel = 4'hF;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack;
  logic [7:0]  irq = '0;
  logic [31:0] mie = '0;
  logic [31:0] mst = '0;
  logic        intr;
  logic [30:0] exc;

  int checks = 0;
  int errors = 0;

  // model state
  int     m_prio [1:8];
  bit [8:1] m_en, m_pend, m_insvc;
  int     m_thr;
  bit     m_mie, m_mst;

  always #5 clk = ~clk;

  plic_lite dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wb_adr_i       (adr),
    .wb_dat_i       (wdat),
    .wb_dat_o       (rdat),
    .wb_sel_i       (sel),
    .wb_we_i        (we),
    .wb_stb_i       (stb),
    .wb_cyc_i       (cyc),
    .wb_ack_o       (ack),
    .irq_src_i      (irq),
    .csr_mie        (mie),
    .csr_mstatus    (mst),
    .Interrupt      (intr),
    .Exception_code (exc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 1; k <= 8; k++) m_prio[k] = 0;
    m_en = '0; m_pend = '0; m_insvc = '0; m_thr = 0;
  endfunction

  // level sources latch whenever not in service
  function automatic void m_sync();
    m_pend |= irq & ~m_insvc;
  endfunction

  // highest priority first, lowest id within a priority
  function automatic int m_winner();
    for (int p = 7; p > m_thr; p--)
      for (int k = 1; k <= 8; k++)
        if (m_pend[k] && m_en[k] && m_prio[k] == p)
          return k;
    return 0;
  endfunction

  task automatic set_csr(input bit ie, input bit me);
    m_mst = ie; m_mie = me;
    mst = ($urandom & ~32'h8) | (ie ? 32'h8 : 32'h0);
    mie = ($urandom & ~32'h800) | (me ? 32'h800 : 32'h0);
  endtask

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d,
                     output logic [31:0] r);
    int n;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    chk("ack_seen", {31'b0, ack}, 32'h1);
    r = rdat;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_single", {31'b0, ack}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] r);
    bus(1'b0, a, 32'h0, r);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] e);
    logic [31:0] r;
    rd(a, r);
    chk(tag, r, e);
  endtask

  task automatic set_prio(input int k, input int p);
    wr(BASE + 32'(4 * k), 32'(p));
    m_prio[k] = p;
  endtask

  task automatic set_en(input bit [8:1] v);
    wr(A_EN, {23'b0, v, 1'b0});
    m_en = v;
  endtask

  task automatic set_thr(input int t);
    wr(A_THR, 32'(t));
    m_thr = t;
  endtask

  task automatic claim(input string tag, output int got);
    logic [31:0] r;
    int e;
    e = m_winner();
    rd(A_CLM, r);
    chk(tag, r, 32'(e));
    got = int'(r);
    if (e != 0) begin
      m_pend[e] = 1'b0;
      m_insvc[e] = 1'b1;
    end
  endtask

  task automatic complete(input int id);
    wr(A_CLM, 32'(id));
    if (id >= 1 && id <= 8 && m_insvc[id])
      m_insvc[id] = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    m_sync();
  endtask

  task automatic chk_irq(input string tag);
    bit e;
    e = (m_winner() != 0) && m_mie && m_mst;
    chk({tag, "_irq"}, {31'b0, intr}, {31'b0, e});
    chk({tag, "_exc"}, {1'b0, exc}, e ? 32'd11 : 32'd0);
  endtask

  task automatic chk_pend(input string tag);
    rd_chk(tag, A_PND, {23'b0, m_pend, 1'b0});
  endtask

  initial begin
    int got;
    int k;
    logic [31:0] r;

    m_reset();
    set_csr(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_irq", {31'b0, intr}, 32'h0);
    chk("rst_exc", {1'b0, exc}, 32'h0);
    rst = 0;

    // step 1: reset contents and ack cadence
    rd_chk("t1_pend", A_PND, 32'h0);
    rd_chk("t1_en", A_EN, 32'h0);
    rd_chk("t1_thr", A_THR, 32'h0);
    rd_chk("t1_claim", A_CLM, 32'h0);
    chk("t1_irq", {31'b0, intr}, 32'h0);
    @(posedge clk); #1;
    cyc = 1; stb = 1; adr = A_PND;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t1_ack_alt", {31'b0, ack}, 32'(i % 2 == 0));
    end
    cyc = 0; stb = 0;
    wr(BASE + 32'h0000_1004, 32'hFFFF_FFFF);
    rd_chk("t1_unmapped", BASE + 32'h0000_1004, 32'h0);

    // step 2: single source, latency and claim
    set_prio(3, 2);
    set_en(8'b0000_0100);
    set_csr(1'b1, 1'b1);
    irq = 8'b0000_0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t2_irq_early", {31'b0, intr}, 32'h0);
    @(posedge clk); #1;
    chk("t2_irq_3cyc", {31'b0, intr}, 32'h1);
    chk("t2_exc", {1'b0, exc}, 32'd11);
    m_sync();
    claim("t2_claim", got);
    chk("t2_claim_id", 32'(got), 32'd3);
    @(posedge clk); #1;
    chk("t2_irq_drop", {31'b0, intr}, 32'h0);
    chk_pend("t2_pend_clr");
    irq = '0;
    complete(3);
    settle();

    // step 3: priority order and tie break
    set_prio(2, 5);
    set_prio(5, 5);
    set_prio(6, 7);
    set_en(8'hFF);
    irq = 8'b0011_0010;
    settle();
    chk_irq("t3");
    claim("t3_c1", got);
    chk("t3_first", 32'(got), 32'd6);
    claim("t3_c2", got);
    chk("t3_second", 32'(got), 32'd2);
    claim("t3_c3", got);
    chk("t3_third", 32'(got), 32'd5);
    irq = '0;
    complete(6);
    complete(2);
    complete(5);
    settle();
    chk_irq("t3_idle");

    // step 4: threshold is a strict bound
    set_thr(4);
    set_prio(1, 4);
    irq = 8'b0000_0001;
    settle();
    chk("t4_irq_masked", {31'b0, intr}, 32'h0);
    claim("t4_claim0", got);
    chk("t4_claim0_id", 32'(got), 32'd0);
    set_thr(3);
    settle();
    chk("t4_irq_open", {31'b0, intr}, 32'h1);
    claim("t4_claim1", got);
    irq = '0;
    complete(1);
    settle();

    // step 5: in-service blocking and complete rules
    set_prio(4, 6);
    irq = 8'b0000_1000;
    settle();
    claim("t5_claim", got);
    chk("t5_claim_id", 32'(got), 32'd4);
    settle();
    chk_pend("t5_blocked");
    complete(7);
    settle();
    chk_pend("t5_bad_cmpl");
    complete(4);
    @(posedge clk); #1;
    m_sync();
    chk_pend("t5_repend");
    claim("t5_reclaim", got);
    chk("t5_reclaim_id", 32'(got), 32'd4);
    irq = '0;
    complete(4);
    settle();

    // random rounds
    for (int it = 0; it < 40; it++) begin
      irq = 8'($urandom);
      set_csr($urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 8);
        set_prio(k, $urandom_range(0, 7));
        rd_chk("r_prio", BASE + 32'(4 * k),
               32'(m_prio[k]));
      end
      if ($urandom_range(0, 3) == 0)
        set_en(8'($urandom));
      if ($urandom_range(0, 3) == 0)
        set_thr($urandom_range(0, 3));
      settle();
      chk_irq("r");
      chk_pend("r_pend");
      claim("r_claim", got);
      if ($urandom_range(0, 1) == 1)
        complete($urandom_range(0, 9));
      else if (got != 0)
        complete(got);
      settle();
    end

    // step 6: async reset in the middle of an access
    set_prio(2, 7);
    set_thr(0);
    set_en(8'hFF);
    set_csr(1'b1, 1'b1);
    irq = 8'b0000_0010;
    settle();
    chk("t6_irq_pre", {31'b0, intr}, 32'h1);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = A_PND;
    @(posedge clk); #1;
    chk("t6_ack_pre", {31'b0, ack}, 32'h1);
    #2;
    rst = 1;
    irq = '0;
    #1;
    chk("t6_ack_async", {31'b0, ack}, 32'h0);
    chk("t6_irq_async", {31'b0, intr}, 32'h0);
    chk("t6_exc_async", {1'b0, exc}, 32'h0);
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_reset();
    rd_chk("t6_pend", A_PND, 32'h0);
    rd_chk("t6_en", A_EN, 32'h0);
    rd_chk("t6_thr", A_THR, 32'h0);
    rd_chk("t6_claim", A_CLM, 32'h0);
    for (int j = 1; j <= 8; j++)
      rd_chk("t6_prio", BASE + 32'(4 * j), 32'h0);
    rd(A_EN, r);
    chk("t6_irq_post", {31'b0, intr}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
